// File: rtl/rdm_combine_scheduler.sv
// ---------------------------------------------------------------------------
// rdm_combine_scheduler
//
// Walks the rate-dematching read FSM through every user of one combine job.
// A start pulse in IDLE snapshots the per-user configuration. Each active user
// in index order then gets three steps:
//   - the read FSM is held in reset for FSMRST_CYCLES cycles,
//   - one combine process request is issued with that user's index and sizes,
//   - the scheduler waits for the read-complete pulse.
// Users whose QM is zero are skipped. The block reports per-user completion,
// a job-done pulse and sticky timeout/abort errors.
//
// Ports
//   i_core_clk                  clock
//   i_rx_rst                    synchronous active-high reset
//   i_start                     job start pulse (accepted only in IDLE)
//   i_abort                     terminate current job (ignored in IDLE/DONE)
//   i_user_num                  users in the job, clamped to MAX_USERS
//   i_users_qm                  4-bit QM per user, 0 = skip user
//   i_users_e01_size            14-bit E01 size per user
//   i_users_ncb_size            16-bit Ncb size per user
//   i_RDM_Data_Comp             read-FSM completion pulse
//   o_rx_fsm_rstn               active-low reset to the read FSM
//   o_Combine_process_request   one-cycle request to the read FSM
//   o_Combine_user_index        current user index
//   o_Current_Combine_E01_Size  current user E01 size
//   o_Current_Combine_Ncb_Size  current user Ncb size
//   o_busy                      high in every state except IDLE
//   o_done                      one-cycle job-end pulse
//   o_user_done_bitmap          bit n set when user n completes
//   o_error                     bit0 timeout, bit1 abort; sticky until next start
// ---------------------------------------------------------------------------
module rdm_combine_scheduler #(
    parameter int unsigned FSMRST_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_USERS      = 8
) (
    input  logic                      i_core_clk,
    input  logic                      i_rx_rst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [3:0]                i_user_num,
    input  logic [4*MAX_USERS-1:0]    i_users_qm,
    input  logic [14*MAX_USERS-1:0]   i_users_e01_size,
    input  logic [16*MAX_USERS-1:0]   i_users_ncb_size,
    input  logic                      i_RDM_Data_Comp,
    output logic                      o_rx_fsm_rstn,
    output logic                      o_Combine_process_request,
    output logic [3:0]                o_Combine_user_index,
    output logic [13:0]               o_Current_Combine_E01_Size,
    output logic [15:0]               o_Current_Combine_Ncb_Size,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [MAX_USERS-1:0]      o_user_done_bitmap,
    output logic [1:0]                o_error
);

    localparam int unsigned IDX_W   = (MAX_USERS > 1) ? $clog2(MAX_USERS) : 1;
    localparam logic [3:0]  MAX_U   = 4'(MAX_USERS);
    localparam logic [3:0]  FR_INIT = 4'(FSMRST_CYCLES - 1);
    localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_CYCLES);

    typedef enum logic [6:0] {
        S_IDLE   = 7'b000_0001,
        S_LOAD   = 7'b000_0010,
        S_FSMRST = 7'b000_0100,
        S_REQ    = 7'b000_1000,
        S_WAIT   = 7'b001_0000,
        S_NEXT   = 7'b010_0000,
        S_DONE   = 7'b100_0000
    } state_e;

    // Per-user field extraction from the packed snapshot vectors.
    function automatic logic [3:0] sel_qm(input logic [4*MAX_USERS-1:0] vec,
                                          input logic [IDX_W-1:0] sel);
        int unsigned base;
        base = 32'(sel) * 32'd4;
        return vec[base +: 4];
    endfunction

    function automatic logic [13:0] sel_e01(input logic [14*MAX_USERS-1:0] vec,
                                            input logic [IDX_W-1:0] sel);
        int unsigned base;
        base = 32'(sel) * 32'd14;
        return vec[base +: 14];
    endfunction

    function automatic logic [15:0] sel_ncb(input logic [16*MAX_USERS-1:0] vec,
                                            input logic [IDX_W-1:0] sel);
        int unsigned base;
        base = 32'(sel) * 32'd16;
        return vec[base +: 16];
    endfunction

    state_e                    state_q;
    logic [4*MAX_USERS-1:0]    qm_q;
    logic [14*MAX_USERS-1:0]   e01_q;
    logic [16*MAX_USERS-1:0]   ncb_q;
    logic [3:0]                num_q;
    logic [3:0]                idx_q;       // internal walk index, may reach num_q
    logic [3:0]                rst_cnt_q;   // FSMRST down-counter
    logic [15:0]               to_cnt_q;    // WAIT_COMP timeout counter

    logic                      rstn_q;
    logic                      req_q;
    logic [3:0]                index_q;
    logic [13:0]               e01_out_q;
    logic [15:0]               ncb_out_q;
    logic                      busy_q;
    logic                      done_q;
    logic [MAX_USERS-1:0]      bitmap_q;
    logic [1:0]                err_q;

    logic [3:0]                num_clamp_s;
    logic [3:0]                cur_qm_s;
    logic [13:0]               cur_e01_s;
    logic [15:0]               cur_ncb_s;
    logic                      abortable_s;
    logic [3:0]                idx_inc_s;
    logic [15:0]               to_inc_s;

    assign num_clamp_s = (i_user_num > MAX_U) ? MAX_U : i_user_num;
    assign cur_qm_s    = sel_qm(qm_q, idx_q[IDX_W-1:0]);
    assign cur_e01_s   = sel_e01(e01_q, idx_q[IDX_W-1:0]);
    assign cur_ncb_s   = sel_ncb(ncb_q, idx_q[IDX_W-1:0]);
    assign abortable_s = (state_q != S_IDLE) && (state_q != S_DONE);
    assign idx_inc_s   = idx_q + 4'd1;
    assign to_inc_s    = to_cnt_q + 16'd1;

    // Scheduler FSM: state, counters, snapshot and all registered outputs.
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_q   <= S_IDLE;
            qm_q      <= '0;
            e01_q     <= '0;
            ncb_q     <= '0;
            num_q     <= 4'd0;
            idx_q     <= 4'd0;
            rst_cnt_q <= 4'd0;
            to_cnt_q  <= 16'd0;
            rstn_q    <= 1'b1;
            req_q     <= 1'b0;
            index_q   <= 4'd0;
            e01_out_q <= 14'd0;
            ncb_out_q <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bitmap_q  <= '0;
            err_q     <= 2'b00;
        end else if (i_abort && abortable_s) begin
            // Abort wins over completion/timeout; completed users stay marked.
            state_q  <= S_DONE;
            err_q[1] <= 1'b1;
            rstn_q   <= 1'b1;
            req_q    <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        qm_q     <= i_users_qm;
                        e01_q    <= i_users_e01_size;
                        ncb_q    <= i_users_ncb_size;
                        num_q    <= num_clamp_s;
                        idx_q    <= 4'd0;
                        index_q  <= 4'd0;
                        bitmap_q <= '0;
                        err_q    <= 2'b00;
                        busy_q   <= 1'b1;
                        if (num_clamp_s == 4'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (cur_qm_s == 4'd0) begin
                        state_q <= S_NEXT;
                    end else begin
                        index_q   <= idx_q;
                        e01_out_q <= cur_e01_s;
                        ncb_out_q <= cur_ncb_s;
                        rst_cnt_q <= FR_INIT;
                        rstn_q    <= 1'b0;
                        state_q   <= S_FSMRST;
                    end
                end
                S_FSMRST: begin
                    if (rst_cnt_q == 4'd0) begin
                        rstn_q  <= 1'b1;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 4'd1;
                    end
                end
                S_REQ: begin
                    req_q    <= 1'b0;
                    to_cnt_q <= 16'd0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_RDM_Data_Comp) begin
                        bitmap_q[idx_q[IDX_W-1:0]] <= 1'b1;
                        state_q <= S_NEXT;
                    end else if (to_inc_s == TO_LIM) begin
                        to_cnt_q <= to_inc_s;
                        err_q[0] <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        to_cnt_q <= to_inc_s;
                    end
                end
                S_NEXT: begin
                    idx_q <= idx_inc_s;
                    if (idx_inc_s == num_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    // Illegal one-hot code: park safely in IDLE.
                    state_q <= S_IDLE;
                    rstn_q  <= 1'b1;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_fsm_rstn              = rstn_q;
    assign o_Combine_process_request  = req_q;
    assign o_Combine_user_index       = index_q;
    assign o_Current_Combine_E01_Size = e01_out_q;
    assign o_Current_Combine_Ncb_Size = ncb_out_q;
    assign o_busy                     = busy_q;
    assign o_done                     = done_q;
    assign o_user_done_bitmap         = bitmap_q;
    assign o_error                    = err_q;

endmodule

// File: tb/tb_rdm_combine_scheduler.sv
module tb_rdm_combine_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort_i;
    logic [3:0]   user_num;
    logic [31:0]  users_qm;
    logic [111:0] users_e01;
    logic [127:0] users_ncb;
    logic         comp;
    logic         rstn;
    logic         req;
    logic [3:0]   uidx;
    logic [13:0]  e01_o;
    logic [15:0]  ncb_o;
    logic         busy;
    logic         done;
    logic [7:0]   bitmap;
    logic [1:0]   err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rdm_combine_scheduler #(
        .FSMRST_CYCLES (2),
        .TIMEOUT_CYCLES(16),
        .MAX_USERS     (8)
    ) dut (
        .i_core_clk                (clk),
        .i_rx_rst                  (rst),
        .i_start                   (start),
        .i_abort                   (abort_i),
        .i_user_num                (user_num),
        .i_users_qm                (users_qm),
        .i_users_e01_size          (users_e01),
        .i_users_ncb_size          (users_ncb),
        .i_RDM_Data_Comp           (comp),
        .o_rx_fsm_rstn             (rstn),
        .o_Combine_process_request (req),
        .o_Combine_user_index      (uidx),
        .o_Current_Combine_E01_Size(e01_o),
        .o_Current_Combine_Ncb_Size(ncb_o),
        .o_busy                    (busy),
        .o_done                    (done),
        .o_user_done_bitmap        (bitmap),
        .o_error                   (err)
    );

    typedef struct {
        logic [3:0]   num;
        logic [31:0]  qm;
        logic [111:0] e01;
        logic [127:0] ncb;
        int           delay;      // comp this many cycles after request, 0 = never
        int           abort_cyc;  // cycle (after start) to pulse abort, 0 = none
        bit           busy_start; // extra start pulse during WAIT_COMP
        bit           scramble;   // change config inputs mid-job
        int           exp_reqs;
        int           exp_done;   // cycle of o_done, start accepted at cycle 0
        logic [7:0]   exp_bitmap;
        logic [1:0]   exp_err;
    } vec_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [13:0] e01;
        logic [15:0] ncb;
    } req_t;

    req_t exp_q[$];
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        abort_i  = 1'b0;
        comp     = 1'b0;
        user_num = 4'd0;
        users_qm = 32'd0;
        users_e01 = 112'd0;
        users_ncb = 128'd0;
    endtask

    task automatic run_job(input int vi, input vec_t v);
        int   cyc;
        int   comp_at;
        int   lowrun;
        int   nreq;
        int   lim;
        int   pushed;
        bit   done_seen;
        req_t r;
        // Scoreboard: expected requests, in index order, from the bench's copy.
        lim = (v.num > 4'd8) ? 8 : int'(v.num);
        pushed = 0;
        for (int n = 0; n < lim; n++) begin
            if (v.qm[n*4 +: 4] != 4'd0 && pushed < v.exp_reqs) begin
                r.idx = 4'(n);
                r.e01 = v.e01[n*14 +: 14];
                r.ncb = v.ncb[n*16 +: 16];
                exp_q.push_back(r);
                pushed++;
            end
        end
        @(negedge clk);
        user_num  = v.num;
        users_qm  = v.qm;
        users_e01 = v.e01;
        users_ncb = v.ncb;
        start     = 1'b1;
        cyc = 0; comp_at = -1; lowrun = 0; nreq = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (req) begin
                nreq++;
                chk($sformatf("v%0d_req_rstn", vi), 32'(rstn), 32'd1);
                chk($sformatf("v%0d_rstn_low_cycles", vi), 32'(lowrun), 32'd2);
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL v%0d_unexpected_req: got index %0d expected no request", vi, uidx);
                end else begin
                    r = exp_q.pop_front();
                    chk($sformatf("v%0d_req_index", vi), 32'(uidx), 32'(r.idx));
                    chk($sformatf("v%0d_req_e01", vi), 32'(e01_o), 32'(r.e01));
                    chk($sformatf("v%0d_req_ncb", vi), 32'(ncb_o), 32'(r.ncb));
                end
                if (v.delay > 0) comp_at = cyc + v.delay;
            end
            lowrun = (rstn == 1'b0) ? lowrun + 1 : 0;
            if (done) begin
                done_seen = 1'b1;
                chk($sformatf("v%0d_done_cycle", vi), 32'(cyc), 32'(v.exp_done));
                chk($sformatf("v%0d_bitmap", vi), 32'(bitmap), 32'(v.exp_bitmap));
                chk($sformatf("v%0d_error", vi), 32'(err), 32'(v.exp_err));
                chk($sformatf("v%0d_busy_in_done", vi), 32'(busy), 32'd1);
                idle_inputs();
            end else begin
                start   = v.busy_start && (cyc == 6);
                comp    = (cyc == comp_at);
                abort_i = (v.abort_cyc != 0) && (cyc == v.abort_cyc);
                if (v.scramble && cyc >= 20) begin
                    user_num  = 4'd0;
                    users_qm  = ~v.qm;
                    users_e01 = ~v.e01;
                    users_ncb = ~v.ncb;
                end
            end
        end
        if (!done_seen) begin
            nvec++;
            nerr++;
            $display("FAIL v%0d_done_wait: got no o_done within %0d cycles expected cycle %0d", vi, cyc, v.exp_done);
            idle_inputs();
        end
        @(negedge clk);
        chk($sformatf("v%0d_busy_after", vi), 32'(busy), 32'd0);
        chk($sformatf("v%0d_done_single", vi), 32'(done), 32'd0);
        chk($sformatf("v%0d_error_sticky", vi), 32'(err), 32'(v.exp_err));
        chk($sformatf("v%0d_req_count", vi), 32'(nreq), 32'(v.exp_reqs));
        chk($sformatf("v%0d_queue_left", vi), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rstn"},   32'(rstn),   32'd1);
        chk({tag, "_req"},    32'(req),    32'd0);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_done"},   32'(done),   32'd0);
        chk({tag, "_index"},  32'(uidx),   32'd0);
        chk({tag, "_e01"},    32'(e01_o),  32'd0);
        chk({tag, "_ncb"},    32'(ncb_o),  32'd0);
        chk({tag, "_bitmap"}, 32'(bitmap), 32'd0);
        chk({tag, "_error"},  32'(err),    32'd0);
    endtask

    initial begin
        vec_t v;
        idle_inputs();
        rst = 1'b1;

        // Three active users, 5-cycle comp: 3 x 10 cycles.
        vecs[0] = '{num: 4'd3, qm: 32'h222,
                    e01: {70'd0, 14'd480, 14'd1200, 14'd960},
                    ncb: {80'd0, 16'd512, 16'd2048, 16'd1024},
                    delay: 5, abort_cyc: 0, busy_start: 1'b0, scramble: 1'b0,
                    exp_reqs: 3, exp_done: 31, exp_bitmap: 8'h07, exp_err: 2'b00};
        // Skipped user 1 costs 2 cycles: 10 + 2 + 10.
        vecs[1] = vecs[0];
        vecs[1].qm = 32'h202; vecs[1].exp_reqs = 2; vecs[1].exp_done = 23; vecs[1].exp_bitmap = 8'h05;
        // Timeout: REQ at 4, 16 WAIT cycles 5..20, DONE at 21.
        vecs[2] = vecs[0];
        vecs[2].num = 4'd1; vecs[2].qm = 32'h2; vecs[2].delay = 0; vecs[2].exp_reqs = 1;
        vecs[2].exp_done = 21; vecs[2].exp_bitmap = 8'h00; vecs[2].exp_err = 2'b01;
        // Empty job right after the timeout also clears the sticky error.
        vecs[3] = vecs[0];
        vecs[3].num = 4'd0; vecs[3].exp_reqs = 0; vecs[3].exp_done = 1; vecs[3].exp_bitmap = 8'h00;
        // Start pulse during WAIT_COMP of user 0 changes nothing.
        vecs[4] = vecs[0];
        vecs[4].busy_start = 1'b1;
        // Abort together with comp of user 1 (REQ at 14, comp at 19).
        vecs[5] = vecs[0];
        vecs[5].abort_cyc = 19; vecs[5].exp_reqs = 2; vecs[5].exp_done = 20;
        vecs[5].exp_bitmap = 8'h01; vecs[5].exp_err = 2'b10;
        // Clamp 12 -> 8 users, delay 3: 8 x 8 cycles; config scrambled mid-job.
        v = vecs[0];
        v.num = 4'd12; v.qm = 32'h2222_2222; v.delay = 3; v.scramble = 1'b1;
        for (int n = 0; n < 8; n++) begin
            v.e01[n*14 +: 14] = 14'(100 + 37 * n);
            v.ncb[n*16 +: 16] = 16'(3000 + 111 * n);
        end
        v.exp_reqs = 8; v.exp_done = 65; v.exp_bitmap = 8'hFF;
        vecs[6] = v;
        // Extreme sizes, delay 1: 2 x 6 cycles.
        vecs[7] = vecs[0];
        vecs[7].num = 4'd2; vecs[7].qm = 32'h51; vecs[7].delay = 1;
        vecs[7].e01 = {84'd0, 14'd16383, 14'd1};
        vecs[7].ncb = {96'd0, 16'hFFFF, 16'd0};
        vecs[7].exp_reqs = 2; vecs[7].exp_done = 13; vecs[7].exp_bitmap = 8'h03;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_reset_idle");

        for (int i = 0; i < 8; i++) begin
            run_job(i, vecs[i]);
        end

        // Reset in the middle of WAIT_COMP of user 1 (cycle 16).
        @(negedge clk);
        user_num  = vecs[0].num;
        users_qm  = vecs[0].qm;
        users_e01 = vecs[0].e01;
        users_ncb = vecs[0].ncb;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            comp = (c == 9);
        end
        chk("midrst_pre_bitmap", 32'(bitmap), 32'h01);
        chk("midrst_pre_index", 32'(uidx), 32'd1);
        comp = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        @(negedge clk);
        chk("midrst_hold_rstn", 32'(rstn), 32'd1);
        rst = 1'b0;
        idle_inputs();

        // Recovery job after the reset.
        run_job(8, vecs[7]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rdm_combine_scheduler.md
# rdm_combine_scheduler

Sequences the rate-dematching read FSM across all users of one combine job. On a start pulse it snapshots the per-user configuration (QM, E01 size, Ncb size), then, for each active user in index order, clears the read FSM through its FSM reset, issues one combine process request with that user's index and sizes, and waits for the read-complete pulse. It sits between the receive-chain job control and the RDM read FSM. It reports per-user completion, a job-done pulse and timeout/abort errors.

## Interface
- FSMRST_CYCLES, 2: cycles `o_rx_fsm_rstn` is held low before each request (1..15).
- TIMEOUT_CYCLES, 65535: maximum cycles in WAIT_COMP before a timeout (16-bit counter).
- MAX_USERS, 8: number of user slots.

- i_core_clk  in  1  clock.
- i_rx_rst  in  1  synchronous, active-high reset.
- i_start  in  1  job start pulse; accepted only in IDLE.
- i_abort  in  1  terminate the current job; ignored in IDLE.
- i_user_num  in  4  users in the job; 0 = empty job; values >8 clamp to 8.
- i_users_qm  in  32  4-bit QM per user, user n = [4n+3:4n]; 0 = skip that user.
- i_users_e01_size  in  112  14-bit E01 size per user, user n = [14n+13:14n].
- i_users_ncb_size  in  128  16-bit Ncb size per user, user n = [16n+15:16n].
- i_RDM_Data_Comp  in  1  read-FSM completion pulse.
- o_rx_fsm_rstn  out  1  active-low reset to the read FSM.
- o_Combine_process_request  out  1  one-cycle request to the read FSM.
- o_Combine_user_index  out  4  current user index.
- o_Current_Combine_E01_Size  out  14  current user E01 size.
- o_Current_Combine_Ncb_Size  out  16  current user Ncb size.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle job-end pulse.
- o_user_done_bitmap  out  8  bit n set when user n completes.
- o_error  out  2  bit0 = timeout, bit1 = abort; sticky until the next accepted start.

## Operation
- States: IDLE, LOAD, FSMRST, REQ, WAIT_COMP, NEXT, DONE.
  - One-hot encoding.
  - All outputs are registered and coincide with the state they belong to.
- IDLE, on `i_start`:
  - Snapshot `i_users_qm`, `i_users_e01_size`, `i_users_ncb_size` and the clamped `i_user_num`.
  - Clear the bitmap, `o_error` and the user index.
  - If the user number is 0, go to DONE; otherwise go to LOAD.
  - Configuration inputs that change later in the job are ignored.
- LOAD, for the current index:
  - If the snapshot QM is 0, go to NEXT.
  - Otherwise register the index, E01 size and Ncb size onto the outputs and go to FSMRST.
- FSMRST:
  - `o_rx_fsm_rstn` = 0 for exactly FSMRST_CYCLES cycles (down-counter), then go to REQ.
- REQ:
  - `o_Combine_process_request` = 1 for exactly one cycle.
  - Clear the timeout counter, then go to WAIT_COMP.
- WAIT_COMP:
  - On `i_RDM_Data_Comp` = 1, set bitmap[index] and go to NEXT.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES, set `o_error[0]` and go to DONE.
  - `i_RDM_Data_Comp` is ignored in every other state.
- NEXT:
  - Increment the index.
  - If the new index equals the user number, go to DONE; otherwise go to LOAD.
- DONE: `o_done` = 1 for one cycle, then go to IDLE.
- `i_abort` in any non-IDLE state other than DONE:
  - Set `o_error[1]` and go to DONE.
  - The bitmap keeps completed users.
  - Abort has priority over completion or timeout in the same cycle.
- Size outputs hold their last value from LOAD through IDLE; the index is 0 after reset.
- `i_start` in a non-IDLE state is ignored and does not queue.

## Timing
- Reset values:
  - `o_rx_fsm_rstn` = 1.
  - `o_Combine_process_request`, `o_busy`, `o_done` = 0.
  - Index and sizes = 0.
  - Bitmap = 0x00, `o_error` = 0.
- Reset asserted mid-job:
  - Outputs reach their reset values on the next edge.
  - `o_rx_fsm_rstn` is not pulsed low by reset.
- Start accepted at edge T:
  - LOAD at T+1, FSMRST at T+2..T+1+FSMRST_CYCLES, REQ at T+2+FSMRST_CYCLES.
- Active-user cost: 1 (LOAD) + FSMRST_CYCLES + 1 (REQ) + k (WAIT, k ≥ 1) + 1 (NEXT).
- Skipped-user cost: 2 cycles.
- Empty job: `o_done` one cycle after start acceptance (at T+1).
- Index and size outputs are stable from FSMRST entry until the next LOAD.

## Test plan
- **Three active users:** user_num=3, qm=0x222, E01={960,1200,480}, Ncb={1024,2048,512}, comp 5 cycles after each request. Required: requests with index 0,1,2 and matching sizes, `o_rx_fsm_rstn` low 2 cycles before each, bitmap=0x07, one `o_done`, `o_error`=0.
- **Skipped user:** user_num=3, qm=0x202. Required: requests only for index 0 and 2, bitmap=0x05, user 1 costs 2 cycles.
- **Timeout:** TIMEOUT_CYCLES=16, no comp. Required: `o_error`=01, `o_done` after 16 WAIT cycles, bitmap=0x00, return to IDLE.
- **Empty job and busy start:** user_num=0 → `o_done` at T+1 with no request. A start pulse during WAIT_COMP → no effect on index or bitmap.
- **Abort with simultaneous comp:** abort during WAIT_COMP of user 1 in the same cycle as comp. Required: `o_error`=10, bitmap=0x01, `o_done` next cycle.
- **Clamp and config change:** user_num=12 → exactly 8 requests, bitmap=0xFF. Config inputs changed mid-job → outputs still carry the snapshot values.
